serial_number_transmitter: RTL
==============================

# serial_number_transmitter

Parallel-to-serial transmitter that produces the MSB-first bit stream consumed by the serial divisibility checkers. It accepts one WIDTH-bit number per valid/ready handshake and emits one bit per cycle, with first/last framing. It also tracks the running remainder mod 5 of the bits sent so far, so a bench or downstream checker can be compared cycle by cycle. It sits between a parallel test-vector source and any serial bit-stream consumer in the FSM exercises.

## Interface
- WIDTH, 8, number of bits per word; legal range WIDTH >= 2
- clk  input  1  single clock, all state updates on posedge
- rst  input  1  reset; asynchronous, active-low
- in_valid  input  1  in_data holds a word to send
- in_data  input  WIDTH  word to serialize, MSB sent first
- in_ready  output  1  block can accept a word this cycle
- out_valid  output  1  out_bit is a valid stream bit this cycle
- out_bit  output  1  current serial bit
- out_first  output  1  out_bit is the MSB of a word
- out_last  output  1  out_bit is the LSB of a word
- out_rem  output  3  remainder mod 5 of the word prefix ending with out_bit; range 0..4
- out_div_by_5  output  1  out_rem == 0, qualified by out_valid

## Operation
- FSM states: IDLE and SHIFT.
- IDLE:
  - in_ready = 1.
  - If in_valid: load the shift register with in_data, set the bit counter to WIDTH-1, clear the prefix remainder, go to SHIFT.
- SHIFT:
  - out_valid = 1.
  - out_bit = shift register MSB.
  - out_first = (counter == WIDTH-1).
  - out_last = (counter == 0).
  - Each cycle: shift left by 1, decrement the counter, set prefix_rem <= out_rem.
- Remainder arithmetic:
  - out_rem = (2*p + out_bit) mod 5, where p = 0 when out_first, otherwise prefix_rem.
  - Compute with a 5-entry next-state lookup (0→0/1, 1→2/3, 2→4/0, 3→1/2, 4→3/4 for bit 0/1). No multiplier, no wide modulo.
- Last bit (counter == 0):
  - in_ready = 1.
  - If in_valid: load the new word and stay in SHIFT; its MSB is emitted next cycle with no gap.
  - Otherwise return to IDLE.
- in_ready is 0 during SHIFT except on the last-bit cycle. in_data is ignored unless in_valid && in_ready.
- When out_valid = 0: out_bit, out_first, out_last and out_div_by_5 are 0, and out_rem is 0.

## Timing
- Reset (rst low), asynchronous:
  - state = IDLE; shift register, counter and prefix_rem = 0.
  - out_valid, out_bit, out_first, out_last, out_rem and out_div_by_5 are all 0.
  - in_ready is forced to 0 while rst is low.
- Reset asserted mid-word aborts the word immediately. No partial frame resumes; the first word after reset starts with out_first.
- Latency: the MSB appears the cycle after the accepting handshake edge. A word occupies exactly WIDTH consecutive out_valid cycles.
- Throughput: one word per WIDTH cycles when in_valid is held high.
- All outputs are combinational from registered state only. out_rem also depends on the current out_bit, which is registered. There is no input-to-output combinational path except in_ready gated by rst.

## Structure
- Package serial_pkg holds:
  - the FSM state enum (IDLE, SHIFT);
  - a `next_rem_mod5(rem, bit)` function implementing the lookup above;
  - a constant for the modulus 5.
- Sub-module serial_mod5_tracker holds the prefix_rem register and out_rem logic. It has inputs bit, valid and first, so a checker can reuse it.
- The top module holds the FSM, shift register and $clog2(WIDTH)-bit counter.

## Test plan
- Reset, then in_valid=1 with 8'hA5 for one handshake:
  - out_bit = 1,0,1,0,0,1,0,1;
  - out_rem = 1,2,0,0,0,1,2,0;
  - out_first on bit 1 only, out_last on bit 8;
  - then out_valid=0 and in_ready=1.
- Word 8'h07:
  - bits 0,0,0,0,0,1,1,1;
  - out_rem = 0,0,0,0,0,1,3,2;
  - out_div_by_5 high for the first five bits only.
- Back-to-back 8'hFF then 8'h00 with in_valid held high:
  - 16 contiguous out_valid cycles;
  - the second word is accepted on the last-bit cycle of the first;
  - the second word's out_rem is all 0 (prefix cleared at out_first).
- in_valid pulsed during SHIFT (not on the last bit): no acceptance, in_ready=0, and the stream is undisturbed.
- rst driven low at bit 4 of 8'hA5:
  - all outputs 0 asynchronously.
  - After release, 8'h05 is sent cleanly: out_first on its MSB and final out_rem = 0.
- WIDTH=2 instance sending 2'b11 then 2'b10:
  - out_rem = 1,3 then 1,2;
  - out_first and out_last alternate with no idle gap.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM state type and mod-5 remainder step for serial bit streams
package serial_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int MOD = 5;
  function automatic logic [2:0] next_rem_mod5(input logic [2:0] rem, input logic b);
    if (rem >= 3'(MOD)) return 3'd0;
    case (rem)
      3'd0: return b ? 3'd1 : 3'd0;
      3'd1: return b ? 3'd3 : 3'd2;
      3'd2: return b ? 3'd0 : 3'd4;
      3'd3: return b ? 3'd2 : 3'd1;
      default: return b ? 3'd4 : 3'd3;
    endcase
  endfunction
endpackage

// File: rtl/serial_mod5_tracker.sv
// serial_mod5_tracker: running remainder mod 5 of an MSB-first bit stream, restarted on first
module serial_mod5_tracker
  import serial_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       data_bit,
  input  logic       valid,
  input  logic       first,
  output logic [2:0] out_rem
);
  logic [2:0] prefix_rem;
  always_comb out_rem = valid ? next_rem_mod5(first ? 3'd0 : prefix_rem, data_bit) : 3'd0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) prefix_rem <= 3'd0;
    else prefix_rem <= out_rem;
endmodule

// File: rtl/serial_number_transmitter.sv
// serial_number_transmitter: valid/ready word in, MSB-first framed bit stream out with mod-5 prefix remainder
module serial_number_transmitter
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_bit,
  output logic             out_first,
  output logic             out_last,
  output logic [2:0]       out_rem,
  output logic             out_div_by_5
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] TOP = CW'(WIDTH - 1);
  state_t state;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0] cnt;
  always_comb begin
    out_valid = state == SHIFT;
    out_bit = out_valid & sh[WIDTH-1];
    out_first = out_valid && cnt == TOP;
    out_last = out_valid && cnt == '0;
    in_ready = rst && (state == IDLE || cnt == '0);
    out_div_by_5 = out_valid && out_rem == 3'd0;
  end
  serial_mod5_tracker u_rem (
    .clk(clk), .rst(rst), .data_bit(out_bit), .valid(out_valid), .first(out_first), .out_rem(out_rem)
  );
  // a word offered on the last-bit cycle reloads in place, giving gapless back-to-back frames
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      sh <= '0;
      cnt <= '0;
    end else if (in_valid && in_ready) begin
      state <= SHIFT;
      sh <= in_data;
      cnt <= TOP;
    end else if (state == SHIFT) begin
      state <= cnt == '0 ? IDLE : SHIFT;
      sh <= sh << 1;
      cnt <= cnt - 1'b1;
    end
endmodule
